imx_sublvds_gen: RTL and testbench

Sony subLVDS-style stream generator: the transmit-side counterpart of the capture path. Emits 8 parallel 12-bit channels as a 32-bit nibble-interleaved word per clock, framed with SAV/EAV sync codes for valid and invalid lines, vertical blanking, and a deterministic pixel ramp. Used as a sensor emulator in loopback, and drives the capture block's `datain` in simulation and on-board self-test.

---
 rtl/imx_sublvds_pkg.sv | 49 ++++
 rtl/imx_lane_serializer.sv | 39 +++
 rtl/imx_sublvds_gen.sv | 154 +++++++++++++++
 tb/tb_imx_sublvds_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imx_sublvds_pkg.sv
// Shared subLVDS definitions: sync codes, reserved/fill words, line-state enum and
// the nibble-lane mapping used by both the stream generator and the capture path.
package imx_sublvds_pkg;

  localparam int NUM_CH = 8;
  localparam int WORD_W = 12;
  localparam int BEAT_W = 32;

  localparam logic [WORD_W-1:0] SYNC_PREAMBLE   = 12'hFFF;
  localparam logic [WORD_W-1:0] SYNC_ZERO       = 12'h000;
  localparam logic [WORD_W-1:0] XYZ_SAV_VALID   = 12'h800;
  localparam logic [WORD_W-1:0] XYZ_EAV_VALID   = 12'h9D0;
  localparam logic [WORD_W-1:0] XYZ_SAV_INVALID = 12'hAB0;
  localparam logic [WORD_W-1:0] XYZ_EAV_INVALID = 12'hB60;

  localparam logic [WORD_W-1:0] RESERVED_LO  = 12'h000;
  localparam logic [WORD_W-1:0] RESERVED_HI  = 12'hFFF;
  localparam logic [WORD_W-1:0] BLANK_WORD   = 12'h000;
  localparam logic [WORD_W-1:0] INVALID_FILL = 12'h040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAV,
    ST_PIX,
    ST_EAV,
    ST_HBLANK
  } line_state_e;

  // Beat bit carrying nibble bit (3-k) of channel ch; k=0 is the nibble MSB.
  function automatic int unsigned lane_bit(input int unsigned ch, input int unsigned k);
    return ch + NUM_CH * k;
  endfunction

  function automatic logic [WORD_W-1:0] clamp_pixel(input logic [WORD_W-1:0] raw);
    if (raw == RESERVED_LO) return RESERVED_LO + 12'd1;
    if (raw == RESERVED_HI) return RESERVED_HI - 12'd1;
    return raw;
  endfunction

  function automatic logic [WORD_W-1:0] sync_word(input logic [1:0] idx,
                                                  input logic [WORD_W-1:0] xyz);
    case (idx)
      2'd0:    return SYNC_PREAMBLE;
      2'd3:    return xyz;
      default: return SYNC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/imx_lane_serializer.sv
// Selects one nibble of each channel's 12-bit word by phase and registers the
// resulting 32-bit nibble-interleaved beat.
module imx_lane_serializer
  import imx_sublvds_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0][WORD_W-1:0]  words_i,
  input  logic [1:0]                     phase_i,
  output logic [BEAT_W-1:0]              beat_o
);

  logic [BEAT_W-1:0] beat_d;
  logic [BEAT_W-1:0] beat_q;
  logic [3:0]        nib;

  always_comb begin
    beat_d = '0;
    nib    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (phase_i)
        2'd0:    nib = words_i[c][11:8];
        2'd1:    nib = words_i[c][7:4];
        default: nib = words_i[c][3:0];
      endcase
      for (int k = 0; k < 4; k++) begin
        beat_d[lane_bit(c, k)] = nib[3-k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) beat_q <= '0;
    else       beat_q <= beat_d;
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/imx_sublvds_gen.sv
// subLVDS sensor emulator: frames 8 parallel 12-bit channels with SAV/EAV sync codes,
// vertical blanking lines and a per-frame shifted pixel ramp.
module imx_sublvds_gen
  import imx_sublvds_pkg::*;
#(
  parameter int          ACTIVE_WORDS = 1920,
  parameter int          HBLANK_WORDS = 16,
  parameter int          V_TOP        = 8,
  parameter int          V_ACTIVE     = 1080,
  parameter int          V_BOTTOM     = 8,
  parameter logic [11:0] CH_STEP      = 12'h010
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [BEAT_W-1:0]  dataout_o,
  output logic               frame_active_o,
  output logic               pix_valid_o,
  output logic [7:0]         frame_cnt_o,
  output line_state_e        dbg_state_o
);

  localparam int MAXW   = (ACTIVE_WORDS > HBLANK_WORDS)
                          ? ((ACTIVE_WORDS > 4) ? ACTIVE_WORDS : 4)
                          : ((HBLANK_WORDS > 4) ? HBLANK_WORDS : 4);
  localparam int WCNT_W = $clog2(MAXW);
  localparam int LINES  = V_TOP + V_ACTIVE + V_BOTTOM;
  localparam int LCNT_W = (LINES > 1) ? $clog2(LINES) : 1;

  line_state_e        state_q;
  logic [1:0]         phase_q;
  logic [WCNT_W-1:0]  word_q;
  logic [LCNT_W-1:0]  line_q;
  logic [7:0]         frame_cnt_q;

  // Word/state counters only move on phase 2, so each word spans exactly 3 beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      word_q      <= '0;
      line_q      <= '0;
      frame_cnt_q <= 8'd0;
    end else if (state_q == ST_IDLE) begin
      if (en_i) begin
        state_q <= ST_SAV;
        phase_q <= 2'd0;
        word_q  <= '0;
        line_q  <= '0;
      end
    end else if (phase_q != 2'd2) begin
      phase_q <= phase_q + 2'd1;
    end else begin
      phase_q <= 2'd0;
      word_q  <= word_q + WCNT_W'(1);
      case (state_q)
        ST_SAV: if (word_q == WCNT_W'(3)) begin
          state_q <= ST_PIX;
          word_q  <= '0;
        end
        ST_PIX: if (word_q == WCNT_W'(ACTIVE_WORDS - 1)) begin
          state_q <= ST_EAV;
          word_q  <= '0;
        end
        ST_EAV: if (word_q == WCNT_W'(3)) begin
          state_q <= ST_HBLANK;
          word_q  <= '0;
        end
        ST_HBLANK: if (word_q == WCNT_W'(HBLANK_WORDS - 1)) begin
          word_q <= '0;
          if (line_q == LCNT_W'(LINES - 1)) begin
            line_q      <= '0;
            frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q     <= en_i ? ST_SAV : ST_IDLE;
          end else begin
            line_q  <= line_q + LCNT_W'(1);
            state_q <= ST_SAV;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic                           line_valid;
  logic [NUM_CH-1:0][WORD_W-1:0]  words_d;
  logic                           fa_d;
  logic                           pv_d;

  assign line_valid = (line_q >= LCNT_W'(V_TOP)) && (line_q < LCNT_W'(V_TOP + V_ACTIVE));

  always_comb begin
    words_d = '0;
    fa_d    = (state_q != ST_IDLE);
    pv_d    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (state_q)
        ST_SAV: words_d[c] = sync_word(word_q[1:0],
                                       line_valid ? XYZ_SAV_VALID : XYZ_SAV_INVALID);
        ST_PIX: words_d[c] = line_valid
                             ? clamp_pixel(WORD_W'(word_q) + WORD_W'(c) * CH_STEP
                                           + {4'b0, frame_cnt_q})
                             : INVALID_FILL;
        ST_EAV: words_d[c] = sync_word(word_q[1:0],
                                       line_valid ? XYZ_EAV_VALID : XYZ_EAV_INVALID);
        ST_HBLANK: words_d[c] = BLANK_WORD;
        default:   words_d[c] = '0;
      endcase
    end
    if (state_q == ST_PIX) pv_d = line_valid;
  end

  logic [NUM_CH-1:0][WORD_W-1:0]  words_s1_q;
  logic [1:0]                     phase_s1_q;
  logic                           fa_s1_q, pv_s1_q, fa_q, pv_q;
  logic [7:0]                     fc_s1_q, fc_q;

  // Flags travel through the same two register stages as the data beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      words_s1_q <= '0;
      phase_s1_q <= 2'd0;
      fa_s1_q    <= 1'b0;
      pv_s1_q    <= 1'b0;
      fc_s1_q    <= 8'd0;
      fa_q       <= 1'b0;
      pv_q       <= 1'b0;
      fc_q       <= 8'd0;
    end else begin
      words_s1_q <= words_d;
      phase_s1_q <= phase_q;
      fa_s1_q    <= fa_d;
      pv_s1_q    <= pv_d;
      fc_s1_q    <= frame_cnt_q;
      fa_q       <= fa_s1_q;
      pv_q       <= pv_s1_q;
      fc_q       <= fc_s1_q;
    end
  end

  imx_lane_serializer u_ser (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .words_i (words_s1_q),
    .phase_i (phase_s1_q),
    .beat_o  (dataout_o)
  );

  assign frame_active_o = fa_q;
  assign pix_valid_o    = pv_q;
  assign frame_cnt_o    = fc_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_imx_sublvds_gen.sv
// Directed bench for imx_sublvds_gen: decodes the beat stream into 12-bit words per
// channel and compares them with hand-computed sync codes and ramp values.
module tb_imx_sublvds_gen;
  import imx_sublvds_pkg::*;

  localparam int WPL = 14;        // words per line: 4 + 4 + 4 + 2
  localparam int WPF = 4 * WPL;   // 4 lines per frame

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] dataout;
  logic        frame_active;
  logic        pix_valid;
  logic [7:0]  frame_cnt;
  line_state_e dbg_state;

  always #5 clk = ~clk;

  imx_sublvds_gen #(
    .ACTIVE_WORDS (4),
    .HBLANK_WORDS (2),
    .V_TOP        (1),
    .V_ACTIVE     (2),
    .V_BOTTOM     (1),
    .CH_STEP      (12'h010)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .dataout_o      (dataout),
    .frame_active_o (frame_active),
    .pix_valid_o    (pix_valid),
    .frame_cnt_o    (frame_cnt),
    .dbg_state_o    (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [95:0] decode(input logic [31:0] x0, input logic [31:0] x1,
                                         input logic [31:0] x2);
    logic [95:0] w;
    w = '0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        w[c*12 + 11 - k] = x0[c + 8*k];
        w[c*12 + 7 - k]  = x1[c + 8*k];
        w[c*12 + 3 - k]  = x2[c + 8*k];
      end
    end
    return w;
  endfunction

  // Stream monitor: rebuilds words from 3-beat groups while frame_active is high.
  bit          mon_on = 1'b0;
  int          ph = 0;
  int          fa_fall = 0;
  int          reserved_hits = 0;
  logic        fa_prev = 1'b0;
  logic [31:0] b0, b1;
  logic [7:0]  fc0;
  logic [2:0]  pvb;
  logic [95:0] mw;
  logic [95:0] wq[$];
  logic [2:0]  pvq[$];
  logic [7:0]  fcq[$];

  always @(negedge clk) begin
    if (mon_on && fa_prev && !frame_active) fa_fall++;
    fa_prev = frame_active;
    if (!mon_on || !frame_active) begin
      ph  = 0;
      pvb = 3'b000;
    end else begin
      case (ph)
        0: begin b0 = dataout; fc0 = frame_cnt; pvb[0] = pix_valid; end
        1: begin b1 = dataout; pvb[1] = pix_valid; end
        default: begin
          pvb[2] = pix_valid;
          mw = decode(b0, b1, dataout);
          wq.push_back(mw);
          pvq.push_back(pvb);
          fcq.push_back(fc0);
          if (pvb != 3'b000) begin
            if (pvb != 3'b111) reserved_hits++;
            for (int c = 0; c < 8; c++)
              if (mw[c*12 +: 12] == 12'h000 || mw[c*12 +: 12] == 12'hFFF) reserved_hits++;
          end
        end
      endcase
      ph = (ph + 1) % 3;
    end
  end

  function automatic logic [11:0] wd(input int idx, input int c);
    return wq[idx][c*12 +: 12];
  endfunction

  task automatic wait_words(input int n, input int budget);
    int t;
    t = 0;
    while (wq.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    check($sformatf("wait_words_%0d", n), 96'(wq.size() >= n), 96'd1);
  endtask

  task automatic clear_queues();
    wq.delete();
    pvq.delete();
    fcq.delete();
  endtask

  int cnt_a, cnt_b, cnt_c;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dataout", 96'(dataout), 96'd0);
    check("rst_frame_active", 96'(frame_active), 96'd0);
    check("rst_pix_valid", 96'(pix_valid), 96'd0);
    check("rst_frame_cnt", 96'(frame_cnt), 96'd0);
    check("rst_state", 96'(dbg_state), 96'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle_dataout", 96'(dataout), 96'd0);

    // Frame 0 and 1, back to back
    fa_fall = 0;
    mon_on  = 1'b1;
    en      = 1'b1;
    @(negedge clk);
    check("lat_beat1", 96'(dataout), 96'd0);
    @(negedge clk);
    check("lat_beat2", 96'(dataout), 96'd0);
    @(negedge clk);
    check("first_sav_beat", 96'(dataout), 96'hFFFF_FFFF);
    check("first_sav_fa", 96'(frame_active), 96'd1);
    wait_words(WPF, 400);

    check("f0_l0_sav0", wq[0], {8{12'hFFF}});
    check("f0_l0_sav1", wq[1], 96'd0);
    check("f0_l0_sav2", wq[2], 96'd0);
    check("f0_l0_sav3", wq[3], {8{12'hAB0}});
    check("f0_l0_pix0", wq[4], {8{12'h040}});
    check("f0_l0_pix3", wq[7], {8{12'h040}});
    check("f0_l0_eav0", wq[8], {8{12'hFFF}});
    check("f0_l0_eav3", wq[11], {8{12'hB60}});
    check("f0_l0_hblank", wq[12], 96'd0);
    check("f0_l1_sav3", wq[WPL+3], {8{12'h800}});
    check("f0_l1_pix0", wq[WPL+4],
          {12'h070, 12'h060, 12'h050, 12'h040, 12'h030, 12'h020, 12'h010, 12'h001});
    check("f0_l1_pix1", wq[WPL+5],
          {12'h071, 12'h061, 12'h051, 12'h041, 12'h031, 12'h021, 12'h011, 12'h001});
    check("f0_l1_pix3", wq[WPL+7],
          {12'h073, 12'h063, 12'h053, 12'h043, 12'h033, 12'h023, 12'h013, 12'h003});
    check("f0_l1_eav3", wq[WPL+11], {8{12'h9D0}});
    check("f0_l2_sav3", wq[2*WPL+3], {8{12'h800}});
    check("f0_l3_sav3", wq[3*WPL+3], {8{12'hAB0}});
    check("f0_fc", 96'(fcq[0]), 96'd0);

    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < WPL; i++) begin
      cnt_a += $countones(pvq[i]);
      cnt_b += $countones(pvq[WPL+i]);
    end
    for (int i = 0; i < WPF; i++) cnt_c += $countones(pvq[i]);
    check("pv_line0_cycles", 96'(cnt_a), 96'd0);
    check("pv_line1_cycles", 96'(cnt_b), 96'd12);
    check("pv_line1_first", 96'(pvq[WPL+4]), 96'd7);
    check("pv_frame0_cycles", 96'(cnt_c), 96'd24);

    wait_words(WPF + 2*WPL, 400);
    en = 1'b0;
    wait_words(2*WPF, 400);
    check("f1_fc", 96'(fcq[WPF]), 96'd1);
    check("f1_l0_sav0", wq[WPF], {8{12'hFFF}});
    check("f1_l1_pix0", wq[WPF+WPL+4],
          {12'h071, 12'h061, 12'h051, 12'h041, 12'h031, 12'h021, 12'h011, 12'h001});
    check("f1_l1_pix3", wq[WPF+WPL+7],
          {12'h074, 12'h064, 12'h054, 12'h044, 12'h034, 12'h024, 12'h014, 12'h004});

    cnt_a = 0;
    repeat (30) begin
      @(negedge clk);
      if (dataout != 32'd0 || frame_active || pix_valid) cnt_a++;
    end
    check("idle_after_frames", 96'(cnt_a), 96'd0);
    check("words_two_frames", 96'(wq.size()), 96'(2*WPF));
    check("fa_falls", 96'(fa_fall), 96'd1);
    check("fc_after_two", 96'(frame_cnt), 96'd2);

    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 3; i < 2*WPF; i++) begin
      if (wd(i-3, 0) == 12'hFFF && wd(i-2, 0) == 12'h000 && wd(i-1, 0) == 12'h000) begin
        if (wd(i, 0) == 12'h800) cnt_a++;
        if (wd(i, 0) == 12'h9D0) cnt_b++;
        if (wd(i, 0) == 12'hAB0) cnt_c++;
      end
    end
    check("sav_valid_count", 96'(cnt_a), 96'd4);
    check("eav_valid_count", 96'(cnt_b), 96'd4);
    check("sav_invalid_count", 96'(cnt_c), 96'd4);

    // Reset in the middle of line 1 pixels
    clear_queues();
    en = 1'b1;
    wait_words(WPL + 5, 400);
    @(negedge clk);
    rst    = 1'b1;
    mon_on = 1'b0;
    @(negedge clk);
    check("midrst_dataout", 96'(dataout), 96'd0);
    check("midrst_fa", 96'(frame_active), 96'd0);
    check("midrst_pv", 96'(pix_valid), 96'd0);
    check("midrst_fc", 96'(frame_cnt), 96'd0);
    rst = 1'b0;
    clear_queues();
    mon_on = 1'b1;
    @(negedge clk);
    check("restart_lat1", 96'(dataout), 96'd0);
    @(negedge clk);
    check("restart_lat2", 96'(dataout), 96'd0);
    wait_words(4, 50);
    check("restart_sav0", wq[0], {8{12'hFFF}});
    check("restart_sav3", wq[3], {8{12'hAB0}});
    check("restart_fc", 96'(fcq[0]), 96'd0);

    // Run through the frame_cnt wrap
    reserved_hits = 0;
    wait_words(257*WPF, 50000);
    check("fc_255", 96'(fcq[255*WPF]), 96'd255);
    check("fc_wrap", 96'(fcq[256*WPF]), 96'd0);
    check("f255_l1_pix0", wq[255*WPF+WPL+4],
          {12'h16F, 12'h15F, 12'h14F, 12'h13F, 12'h12F, 12'h11F, 12'h10F, 12'h0FF});
    check("f255_l1_pix1", wq[255*WPF+WPL+5],
          {12'h170, 12'h160, 12'h150, 12'h140, 12'h130, 12'h120, 12'h110, 12'h100});
    check("f256_l1_pix0", wq[256*WPF+WPL+4],
          {12'h070, 12'h060, 12'h050, 12'h040, 12'h030, 12'h020, 12'h010, 12'h001});
    check("payload_reserved", 96'(reserved_hits), 96'd0);

    en     = 1'b0;
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
